// File: rtl/fetch_queue_unit.sv
// Instruction fetch stage: PC register, in-order imem requests, DEPTH-entry PC/instr queue to decode.
// Optional macro FETCH_PERF_EN adds saturating redirect / queue-full cycle counters.
module fetch_queue_unit #(
    parameter int                WIDTH       = 8,
    parameter int                INSTR_WIDTH = 32,
    parameter int                INCREMENT   = 1,
    parameter int                DEPTH       = 4,
    parameter logic [WIDTH-1:0]  RESET_PC    = '0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   redirect_valid,
    input  logic [WIDTH-1:0]       redirect_pc,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [WIDTH-1:0]       imem_req_addr,
    input  logic                   imem_resp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_resp_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic [WIDTH-1:0]       out_pc,
    output logic [WIDTH-1:0]       out_pc_next
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]            perf_redirects,
    output logic [15:0]            perf_full_cycles
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int DW = $clog2(2 * DEPTH) + 1;

    typedef enum logic {RUN, DISCARD} state_t;

    state_t                 state, state_next;
    logic [WIDTH-1:0]       pc;
    logic [WIDTH-1:0]       ent_pc    [DEPTH];
    logic [INSTR_WIDTH-1:0] ent_instr [DEPTH];
    logic [DEPTH-1:0]       ent_filled;
    logic [PW-1:0]          head, fill, tail;
    logic [CW-1:0]          count, unfilled;
    logic [DW-1:0]          drop_cnt, drop_next;
    logic                   full, req_fire, resp_fill, pop;

    assign full           = (count == CW'(DEPTH));
    assign imem_req_valid = !reset && !redirect_valid && !full;
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses are dropped while stale ones remain, and ignored if nothing is waiting for one.
    assign resp_fill = imem_resp_valid && !redirect_valid && (drop_cnt == '0) && (unfilled != '0);

    assign out_valid   = ent_filled[head] && !redirect_valid;
    assign out_instr   = out_valid ? ent_instr[head] : '0;
    assign out_pc      = out_valid ? ent_pc[head] : '0;
    assign out_pc_next = out_valid ? ent_pc[head] + WIDTH'(INCREMENT) : '0;
    assign pop         = out_valid && out_ready;

    always_comb begin
        drop_next  = drop_cnt;
        state_next = state;
        if (redirect_valid) begin
            // Every allocated-but-unfilled entry still has a response in flight.
            drop_next = drop_cnt + DW'(unfilled)
                      - DW'(imem_resp_valid && (drop_cnt != '0 || unfilled != '0));
        end else if (imem_resp_valid && drop_cnt != '0) begin
            drop_next = drop_cnt - DW'(1);
        end
        case (state)
            RUN:     if (drop_next != '0) state_next = DISCARD;
            DISCARD: if (drop_next == '0) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            drop_cnt <= '0;
        end else begin
            state    <= state_next;
            drop_cnt <= drop_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc         <= RESET_PC;
            head       <= '0;
            fill       <= '0;
            tail       <= '0;
            count      <= '0;
            unfilled   <= '0;
            ent_filled <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_pc[i]    <= '0;
                ent_instr[i] <= '0;
            end
        end else if (redirect_valid) begin
            pc         <= redirect_pc;
            head       <= '0;
            fill       <= '0;
            tail       <= '0;
            count      <= '0;
            unfilled   <= '0;
            ent_filled <= '0;
        end else begin
            // Alloc, fill and pop always touch distinct slots when they coincide.
            if (req_fire) begin
                ent_pc[tail]     <= pc;
                ent_filled[tail] <= 1'b0;
                tail             <= tail + PW'(1);
                pc               <= pc + WIDTH'(INCREMENT);
            end
            if (resp_fill) begin
                ent_instr[fill]  <= imem_resp_data;
                ent_filled[fill] <= 1'b1;
                fill             <= fill + PW'(1);
            end
            if (pop) begin
                ent_filled[head] <= 1'b0;
                head             <= head + PW'(1);
            end
            count    <= count + CW'(req_fire) - CW'(pop);
            unfilled <= unfilled + CW'(req_fire) - CW'(resp_fill);
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_redirects   <= '0;
            perf_full_cycles <= '0;
        end else begin
            if (redirect_valid && perf_redirects != 16'hFFFF)
                perf_redirects <= perf_redirects + 16'd1;
            if (full && perf_full_cycles != 16'hFFFF)
                perf_full_cycles <= perf_full_cycles + 16'd1;
        end
    end
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: stream, backpressure, PC wrap, redirect/drop and async reset.
module tb_fetch_queue_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [7:0]  redirect_pc = 8'h00;
    logic        imem_req_valid;
    logic        mem_ready = 1'b1;
    logic [7:0]  imem_req_addr;
    logic        mem_rv;
    logic [31:0] mem_rd;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic [7:0]  out_pc, out_pc_next;

    logic        fe_req_valid, fe_rv;
    logic [7:0]  fe_addr, fe_ra;
    logic        fe_out_valid;
    logic [31:0] fe_out_instr;
    logic [7:0]  fe_out_pc, fe_out_pc_next;

    int checks = 0;
    int errors = 0;
    int lat = 1;
    int acc;

    logic [2:0] pv;
    logic [7:0] pa [0:2];

    always #5 clock = ~clock;

    fetch_queue_unit #(.WIDTH(8), .INSTR_WIDTH(32), .INCREMENT(1), .DEPTH(4), .RESET_PC(8'h00)) dut (
        .clock(clock), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(mem_ready), .imem_req_addr(imem_req_addr),
        .imem_resp_valid(mem_rv), .imem_resp_data(mem_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .out_pc_next(out_pc_next)
    );

    fetch_queue_unit #(.WIDTH(8), .INSTR_WIDTH(32), .INCREMENT(1), .DEPTH(4), .RESET_PC(8'hFE)) dut_fe (
        .clock(clock), .reset(reset),
        .redirect_valid(1'b0), .redirect_pc(8'h00),
        .imem_req_valid(fe_req_valid), .imem_req_ready(1'b1), .imem_req_addr(fe_addr),
        .imem_resp_valid(fe_rv), .imem_resp_data(32'hA000_0000 | {24'h0, fe_ra}),
        .out_valid(fe_out_valid), .out_ready(1'b1), .out_instr(fe_out_instr),
        .out_pc(fe_out_pc), .out_pc_next(fe_out_pc_next)
    );

    // Memory model: fixed latency of 1 or 3 cycles, data = 0xA000_0000 | addr.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            pv  <= 3'b000;
            acc <= 0;
        end else begin
            pv    <= {pv[1:0], imem_req_valid && mem_ready};
            pa[0] <= imem_req_addr;
            pa[1] <= pa[0];
            pa[2] <= pa[1];
            if (imem_req_valid && mem_ready) acc <= acc + 1;
        end
    end
    assign mem_rv = (lat == 3) ? pv[2] : pv[0];
    assign mem_rd = 32'hA000_0000 | {24'h0, ((lat == 3) ? pa[2] : pa[0])};

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            fe_rv <= 1'b0;
            fe_ra <= 8'h00;
        end else begin
            fe_rv <= fe_req_valid;
            fe_ra <= fe_addr;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        redirect_valid = 1'b0;
        mem_ready = 1'b1;
        tick;
        tick;
        reset = 1'b0;
    endtask

    initial begin
        // Reset state
        tick;
        check("rst_req_valid", imem_req_valid, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_pc", out_pc, 8'h00);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_out_pc_next", out_pc_next, 8'h00);
        check("rst_drop_cnt", dut.drop_cnt, 4'd0);
        check("rst_fe_addr", fe_addr, 8'hFE);
        tick;
        reset = 1'b0;
        #1;

        // 1-cycle memory streaming, plus RESET_PC=0xFE wrap on the second instance
        check("t1_req_valid", imem_req_valid, 1'b1);
        check("t1_req_addr0", imem_req_addr, 8'h00);
        check("t3_addr_fe", fe_addr, 8'hFE);
        tick;
        check("t1_lat_out_valid", out_valid, 1'b0);
        check("t3_addr_ff", fe_addr, 8'hFF);
        tick;
        check("t1_out_valid0", out_valid, 1'b1);
        check("t1_out_pc0", out_pc, 8'h00);
        check("t1_out_instr0", out_instr, 32'hA000_0000);
        check("t1_out_pc_next0", out_pc_next, 8'h01);
        check("t3_addr_00", fe_addr, 8'h00);
        check("t3_out_pc_fe", fe_out_pc, 8'hFE);
        tick;
        check("t3_out_valid_ff", fe_out_valid, 1'b1);
        check("t3_out_pc_ff", fe_out_pc, 8'hFF);
        check("t3_out_pc_next_wrap", fe_out_pc_next, 8'h00);
        check("t3_out_instr_ff", fe_out_instr, 32'hA000_00FF);
        check("t1_out_pc1", out_pc, 8'h01);
        for (int i = 2; i < 7; i++) begin
            tick;
            check("t1_stream_valid", out_valid, 1'b1);
            check("t1_stream_pc", out_pc, i[7:0]);
            check("t1_stream_instr", out_instr, 32'hA000_0000 | i);
            check("t1_stream_pc_next", out_pc_next, i[7:0] + 8'd1);
        end

        // Backpressure: queue fills with 4 requests, no bypass on first pop
        lat = 1;
        out_ready = 1'b0;
        do_reset;
        repeat (8) tick;
        check("t2_accepted", acc, 4);
        check("t2_full_req_valid", imem_req_valid, 1'b0);
        check("t2_head_valid", out_valid, 1'b1);
        check("t2_head_pc", out_pc, 8'h00);
        out_ready = 1'b1;
        #1;
        check("t2_no_bypass", imem_req_valid, 1'b0);
        tick;
        check("t2_req_after_pop", imem_req_valid, 1'b1);
        check("t2_req_addr4", imem_req_addr, 8'h04);
        check("t2_pop_pc1", out_pc, 8'h01);
        tick;
        check("t2_pop_pc2", out_pc, 8'h02);
        tick;
        check("t2_pop_pc3", out_pc, 8'h03);
        tick;
        check("t2_pop_pc4", out_pc, 8'h04);
        check("t2_pop_instr4", out_instr, 32'hA000_0004);

        // 3-cycle memory, redirect with 2 unfilled entries
        lat = 3;
        out_ready = 1'b1;
        do_reset;
        tick;
        tick;
        mem_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 8'h40;
        #1;
        check("t4_redir_req_valid", imem_req_valid, 1'b0);
        check("t4_redir_out_valid", out_valid, 1'b0);
        tick;
        redirect_valid = 1'b0;
        mem_ready = 1'b1;
        #1;
        check("t4_drop_cnt2", dut.drop_cnt, 4'd2);
        check("t4_req_addr40", imem_req_addr, 8'h40);
        check("t4_req_valid_discard", imem_req_valid, 1'b1);
        tick;
        check("t4_drop_cnt1", dut.drop_cnt, 4'd1);
        check("t4_out_valid_e4", out_valid, 1'b0);
        tick;
        check("t4_drop_cnt0", dut.drop_cnt, 4'd0);
        check("t4_out_valid_e5", out_valid, 1'b0);
        tick;
        check("t4_out_valid_e6", out_valid, 1'b0);
        tick;
        check("t4_out_valid", out_valid, 1'b1);
        check("t4_out_pc40", out_pc, 8'h40);
        check("t4_out_instr40", out_instr, 32'hA000_0040);
        tick;
        check("t4_out_pc41", out_pc, 8'h41);

        // Redirect coinciding with a response while the head could pop
        lat = 1;
        out_ready = 1'b1;
        do_reset;
        tick;
        tick;
        check("t5_pre_valid", out_valid, 1'b1);
        check("t5_pre_pc", out_pc, 8'h00);
        redirect_valid = 1'b1;
        redirect_pc = 8'h80;
        #1;
        check("t5_redir_out_valid", out_valid, 1'b0);
        tick;
        redirect_valid = 1'b0;
        #1;
        check("t5_drop_cnt", dut.drop_cnt, 4'd0);
        check("t5_req_addr80", imem_req_addr, 8'h80);
        tick;
        check("t5_out_valid_e4", out_valid, 1'b0);
        tick;
        check("t5_out_pc80", out_pc, 8'h80);
        check("t5_out_instr80", out_instr, 32'hA000_0080);
        for (int i = 1; i < 5; i++) begin
            tick;
            check("t5_stream_valid", out_valid, 1'b1);
            check("t5_stream_pc", out_pc, 8'h80 + i[7:0]);
        end

        // Asynchronous reset mid-stream
        lat = 1;
        out_ready = 1'b0;
        do_reset;
        tick;
        tick;
        tick;
        check("t6_pre_valid", out_valid, 1'b1);
        check("t6_pre_pc", out_pc, 8'h00);
        #1;
        reset = 1'b1;
        #1;
        check("t6_async_out_valid", out_valid, 1'b0);
        check("t6_async_req_valid", imem_req_valid, 1'b0);
        check("t6_async_out_instr", out_instr, 32'h0);
        tick;
        tick;
        reset = 1'b0;
        #1;
        check("t6_req_valid", imem_req_valid, 1'b1);
        check("t6_req_addr0", imem_req_addr, 8'h00);
        tick;
        tick;
        check("t6_out_valid", out_valid, 1'b1);
        check("t6_out_pc0", out_pc, 8'h00);
        check("t6_out_instr0", out_instr, 32'hA000_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
